mem_b_drain: RTL and testbench
==============================

// Module: mem_b_drain
// PURPOSE
//  Downstream stage of the memory-to-memory transfer datapath. Captures the words
//  the transfer engine writes into memory B, then streams them out in address order
//  over a valid/ready handshake. Produces a mod-2^DATA_W checksum and a one-cycle
//  completion pulse, so the downstream consumer and the bench can check the transfer.
// PARAMETERS
//  DATA_W  8  word width, matches the transfer engine data path
//  DEPTH   4  number of memory-B words captured and drained (power of 2)
//  ADDR_W  2  log2(DEPTH)
// PORTS
//  clock         in   1       single clock, all state updates on posedge
//  Reset         in   1       synchronous, active-high
//  WriteB        in   1       write strobe from transfer engine
//  AddrB         in   ADDR_W  memory-B write address
//  DataInB       in   DATA_W  memory-B write data
//  TransferDone  in   1       1-cycle pulse: upstream has finished writing B
//  OutReady      in   1       downstream consumer can accept a word
//  OutValid      out  1       DataOut/OutIndex carry a valid word
//  DataOut       out  DATA_W  drained word
//  OutIndex      out  ADDR_W  address of the drained word
//  Busy          out  1       high in DRAIN and DONE
//  DrainDone     out  1       1-cycle pulse after the last word is accepted
//  Checksum      out  DATA_W  sum of the accepted words mod 2^DATA_W, held until next drain
//  Overrun       out  1       sticky error flag, cleared only by Reset
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; buffer and entry-valid bits cleared;
//   index=0. All outputs 0: OutValid, DataOut, OutIndex, Busy, DrainDone,
//   Checksum, Overrun.
//  States: IDLE -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - WriteB=1: buf[AddrB] <= DataInB. A later write to the same address overwrites.
//   - TransferDone=1: index <= 0, checksum accumulator <= 0, next state DRAIN.
//   - WriteB and TransferDone in the same cycle: the write is stored first, so it
//     is part of the drain.
//  DRAIN:
//   - OutValid=1, Busy=1, OutIndex=index, DataOut=buf[index].
//   - Entries not written since the last drain read as 0.
//   - Handshake: a word transfers when OutValid && OutReady. DataOut and OutIndex
//     hold stable while OutReady=0. There is no timeout.
//   - On transfer: acc <= acc + DataOut (mod 2^DATA_W) and index <= index+1.
//     If index==DEPTH-1, next state is DONE instead.
//  DONE (exactly 1 cycle):
//   - DrainDone=1, Busy=1, OutValid=0; Checksum <= final acc.
//   - Buffer and entry-valid bits cleared; next state IDLE.
//  Latency:
//   - TransferDone at cycle t gives OutValid at t+1.
//   - With OutReady held high: words at t+1..t+DEPTH, DrainDone at t+DEPTH+1,
//     next IDLE at t+DEPTH+2.
//  Outside DRAIN: OutValid=0 and DataOut=0.
//  Errors: WriteB or TransferDone while in DRAIN/DONE is ignored (no buffer
//   change, no restart) and sets Overrun=1.
//  Reset mid-drain: on the next edge, return to the reset state. No DrainDone
//   pulse; Checksum reads 0.
//  Index wraps only through DONE; it never runs past DEPTH-1.
// TESTING
//  1 Write B[0..3]=01,02,03,FF, TransferDone, OutReady=1 -> OutValid at t+1..t+4,
//    data 01,02,03,FF, OutIndex 0..3; DrainDone at t+5; Checksum=05.
//  2 As 1 but OutReady=0 for 3 cycles on index 1 -> DataOut=02 and OutIndex=1 held
//    stable; DrainDone delayed by 3 cycles; Checksum=05.
//  3 Write only B[2]=0A, TransferDone -> drained data 00,00,0A,00; Checksum=0A;
//    a second drain with no writes -> all 00, Checksum=00.
//  4 WriteB and TransferDone during DRAIN -> Overrun=1 (stays 1); drained data
//    unchanged; exactly one DrainDone.
//  5 Reset=1 at the second accepted word -> next cycle OutValid=0, Busy=0,
//    Checksum=0, Overrun=0; no DrainDone.
//  6 WriteB B[0]=FD and TransferDone in the same cycle -> first drained word FD.

Source files
------------

// File: rtl/mem_b_drain.sv
// mem_b_drain: captures memory-B writes, then streams them out in address
// order over valid/ready with a checksum and a completion pulse.
module mem_b_drain #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              WriteB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataInB,
  input  logic              TransferDone,
  input  logic              OutReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] DataOut,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              Busy,
  output logic              DrainDone,
  output logic [DATA_W-1:0] Checksum,
  output logic              Overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] csum;
  logic              ovr;
  logic [DATA_W-1:0] rd;
  logic              fire;
  logic              last;

  // Unwritten entries read as zero regardless of stale storage
  assign rd   = vld[index] ? mem[index] : '0;
  assign last = (index == ADDR_W'(DEPTH - 1));

  assign Checksum = csum;
  assign Overrun  = ovr;

  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    OutValid  = 1'b0;
    DataOut   = '0;
    OutIndex  = '0;
    Busy      = 1'b0;
    DrainDone = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (TransferDone) state_nxt = DRAIN;
      end
      DRAIN: begin
        OutValid = 1'b1;
        Busy     = 1'b1;
        DataOut  = rd;
        OutIndex = index;
        fire     = OutReady;
        if (fire && last) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        DrainDone = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      vld   <= '0;
      index <= '0;
      acc   <= '0;
      csum  <= '0;
      ovr   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (WriteB) begin
            mem[AddrB] <= DataInB;
            vld[AddrB] <= 1'b1;
          end
          if (TransferDone) begin
            index <= '0;
            acc   <= '0;
          end
        end
        DRAIN: begin
          if (WriteB || TransferDone) ovr <= 1'b1;
          if (fire) begin
            acc <= acc + rd;
            if (!last) index <= index + 1'b1;
          end
        end
        DONE: begin
          if (WriteB || TransferDone) ovr <= 1'b1;
          csum  <= acc;
          vld   <= '0;
          index <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_b_drain.sv
// tb_mem_b_drain: directed self-checking bench for mem_b_drain.
// Inputs are driven 1 time unit after posedge, outputs sampled there too.
module tb_mem_b_drain;

  logic       clock = 1'b0;
  logic       Reset;
  logic       WriteB;
  logic [1:0] AddrB;
  logic [7:0] DataInB;
  logic       TransferDone;
  logic       OutReady;
  logic       OutValid;
  logic [7:0] DataOut;
  logic [1:0] OutIndex;
  logic       Busy;
  logic       DrainDone;
  logic [7:0] Checksum;
  logic       Overrun;

  int n_chk  = 0;
  int n_fail = 0;

  mem_b_drain #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clock(clock),
    .Reset(Reset),
    .WriteB(WriteB),
    .AddrB(AddrB),
    .DataInB(DataInB),
    .TransferDone(TransferDone),
    .OutReady(OutReady),
    .OutValid(OutValid),
    .DataOut(DataOut),
    .OutIndex(OutIndex),
    .Busy(Busy),
    .DrainDone(DrainDone),
    .Checksum(Checksum),
    .Overrun(Overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      WriteB  = 1'b1;
      AddrB   = 2'(i);
      DataInB = w[8*i +: 8];
      tick();
    end
    WriteB = 1'b0;
  endtask

  task automatic start();
    TransferDone = 1'b1;
    tick();
    TransferDone = 1'b0;
  endtask

  // Called in the first DRAIN cycle with OutReady held high
  task automatic run_drain(input string tag, input logic [31:0] w,
                           input logic [7:0] cs);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, OutValid, 1);
      chk({tag, "_data"}, DataOut, w[8*i +: 8]);
      chk({tag, "_idx"}, OutIndex, i);
      chk({tag, "_nodone"}, DrainDone, 0);
      tick();
    end
    chk({tag, "_done"}, DrainDone, 1);
    chk({tag, "_done_busy"}, Busy, 1);
    chk({tag, "_done_novalid"}, OutValid, 0);
    tick();
    chk({tag, "_idle_busy"}, Busy, 0);
    chk({tag, "_idle_done"}, DrainDone, 0);
    chk({tag, "_csum"}, Checksum, cs);
  endtask

  int pulses;

  initial begin
    Reset = 1'b1;
    WriteB = 1'b0;
    AddrB = '0;
    DataInB = '0;
    TransferDone = 1'b0;
    OutReady = 1'b1;
    tick();
    tick();
    chk("rst_valid", OutValid, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_idx", OutIndex, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", DrainDone, 0);
    chk("rst_csum", Checksum, 0);
    chk("rst_ovr", Overrun, 0);
    Reset = 1'b0;
    tick();

    // 1: full drain, checksum wraps (0x105 -> 0x05)
    write4(32'hFF030201);
    chk("t1_idle_valid", OutValid, 0);
    start();
    run_drain("t1", 32'hFF030201, 8'h05);

    // 2: stall 3 cycles on index 1
    write4(32'hFF030201);
    start();
    chk("t2_d0", DataOut, 8'h01);
    tick();
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_data", DataOut, 8'h02);
      chk("t2_hold_idx", OutIndex, 1);
      chk("t2_hold_valid", OutValid, 1);
      tick();
    end
    OutReady = 1'b1;
    chk("t2_rel_data", DataOut, 8'h02);
    chk("t2_rel_idx", OutIndex, 1);
    tick();
    chk("t2_d2", DataOut, 8'h03);
    tick();
    chk("t2_d3", DataOut, 8'hFF);
    chk("t2_nodone", DrainDone, 0);
    tick();
    chk("t2_done", DrainDone, 1);
    tick();
    chk("t2_csum", Checksum, 8'h05);

    // 3: sparse write, then an empty drain
    WriteB = 1'b1;
    AddrB = 2'd2;
    DataInB = 8'h0A;
    tick();
    WriteB = 1'b0;
    start();
    run_drain("t3a", 32'h000A0000, 8'h0A);
    start();
    run_drain("t3b", 32'h00000000, 8'h00);

    // 4: writes and restarts during DRAIN/DONE are ignored
    write4(32'h44332211);
    start();
    chk("t4_d0", DataOut, 8'h11);
    chk("t4_ovr0", Overrun, 0);
    tick();
    WriteB = 1'b1;
    AddrB = 2'd1;
    DataInB = 8'h99;
    TransferDone = 1'b1;
    chk("t4_d1", DataOut, 8'h22);
    tick();
    WriteB = 1'b0;
    TransferDone = 1'b0;
    chk("t4_ovr1", Overrun, 1);
    chk("t4_d2", DataOut, 8'h33);
    tick();
    chk("t4_d3", DataOut, 8'h44);
    TransferDone = 1'b1;
    tick();
    chk("t4_done", DrainDone, 1);
    tick();
    TransferDone = 1'b0;
    chk("t4_norestart", OutValid, 0);
    chk("t4_csum", Checksum, 8'hAA);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (DrainDone) pulses++;
      tick();
    end
    chk("t4_extra_done", pulses, 0);
    chk("t4_ovr_sticky", Overrun, 1);

    // 5: reset on the second accepted word
    write4(32'h08070605);
    start();
    chk("t5_d0", DataOut, 8'h05);
    tick();
    chk("t5_d1", DataOut, 8'h06);
    Reset = 1'b1;
    tick();
    chk("t5_valid", OutValid, 0);
    chk("t5_busy", Busy, 0);
    chk("t5_csum", Checksum, 0);
    chk("t5_ovr", Overrun, 0);
    chk("t5_done", DrainDone, 0);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DrainDone) pulses++;
    end
    chk("t5_no_done", pulses, 0);

    // 6: write and TransferDone in the same cycle
    WriteB = 1'b1;
    AddrB = 2'd0;
    DataInB = 8'hFD;
    TransferDone = 1'b1;
    tick();
    WriteB = 1'b0;
    TransferDone = 1'b0;
    run_drain("t6", 32'h000000FD, 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
